// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
//   Shared types and constants for the ADC window capture block:
//   FSM state encoding, command/result field positions, pipeline depth,
//   the tag carried alongside each beat through the adder pipeline and a
//   helper that sizes the beat-sum bus.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   // Command word fields
   localparam int WIN_LEN_LSB = 0;
   localparam int WIN_LEN_MSB = 15;
   localparam int NUM_WIN_LSB = 16;
   localparam int NUM_WIN_MSB = 47;
   localparam int ABORT_BIT   = 127;

   // Result word fields
   localparam int RES_ACC_LSB = 0;
   localparam int RES_ACC_MSB = 63;
   localparam int RES_TS_LSB  = 64;
   localparam int RES_TS_MSB  = 127;

   // Beat handshake to result write, in cycles
   localparam int PIPE_LATENCY = 3;

   // Samples summed per first-stage partial sum
   localparam int GRP_SIZE = 4;

   typedef struct packed {
      logic        first;
      logic        last;
      logic [63:0] ts;
   } beat_tag_t;

   // Full-precision width of the sum of spb samples of sw bits
   function automatic int beat_sum_w(input int sw, input int spb);
      return sw + $clog2(spb);
   endfunction

endpackage

// File: rtl/adc_beat_adder.sv
// adc_beat_adder
//   Two-stage pipelined signed adder tree over one ADC beat.
//   Stage 1 registers GRP_SIZE-sample partial sums, stage 2 registers the
//   full beat sum. A valid bit and a beat tag ride alongside unchanged.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          drops every in-flight beat (valid bits cleared)
//   vld_i          beat accepted this cycle
//   data_i         packed samples, sample 0 in the LSBs
//   tag_i          first/last/timestamp tag of the beat
//   vld_o, sum_o, tag_o  beat sum two cycles later with its tag
module adc_beat_adder
   import adc_capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH     = 16,
   parameter int SAMPLES_PER_BEAT = 16
) (
   input  logic                                                  clk_i,
   input  logic                                                  rst_ni,
   input  logic                                                  clr_i,
   input  logic                                                  vld_i,
   input  logic [SAMPLE_WIDTH*SAMPLES_PER_BEAT-1:0]              data_i,
   input  beat_tag_t                                             tag_i,
   output logic                                                  vld_o,
   output logic [beat_sum_w(SAMPLE_WIDTH, SAMPLES_PER_BEAT)-1:0] sum_o,
   output beat_tag_t                                             tag_o
);

   localparam int NUM_GRP = SAMPLES_PER_BEAT / GRP_SIZE;
   localparam int PSUM_W  = SAMPLE_WIDTH + $clog2(GRP_SIZE);
   localparam int SUM_W   = beat_sum_w(SAMPLE_WIDTH, SAMPLES_PER_BEAT);

   logic [NUM_GRP-1:0][PSUM_W-1:0] psum_d, psum_q;
   logic [SUM_W-1:0]               sum_d, sum_q;
   logic [2:1]                     vld_pipe_q;
   beat_tag_t                      tag1_q, tag2_q;

   // Sign extension before each add keeps the unsigned adders exact in
   // two's complement.
   always_comb begin
      psum_d = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         for (int k = 0; k < GRP_SIZE; k++) begin
            psum_d[g] = psum_d[g] +
               {{(PSUM_W-SAMPLE_WIDTH){data_i[(g*GRP_SIZE+k)*SAMPLE_WIDTH + SAMPLE_WIDTH-1]}},
                data_i[(g*GRP_SIZE+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
         end
      end
   end

   always_comb begin
      sum_d = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         sum_d = sum_d + {{(SUM_W-PSUM_W){psum_q[g][PSUM_W-1]}}, psum_q[g]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe_q <= '0;
         psum_q     <= '0;
         sum_q      <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
      end else begin
         vld_pipe_q <= clr_i ? 2'b00 : {vld_pipe_q[1], vld_i};
         psum_q     <= psum_d;
         sum_q      <= sum_d;
         tag1_q     <= tag_i;
         tag2_q     <= tag1_q;
      end
   end

   assign vld_o = vld_pipe_q[2];
   assign sum_o = sum_q;
   assign tag_o = tag2_q;

endmodule

// File: rtl/adc_window_capture.sv
// adc_window_capture
//   Integrates ADC stream beats over commanded windows and writes one
//   128-bit {timestamp, accumulator} entry per window into the RTI FIFO.
//   Commands arrive as an RTO strobe plus command word; capture windows
//   therefore start on the RTIO timeline.
// Ports:
//   s00_axis_*        ADC AXI4-Stream slave (tready always 1)
//   counter           RTIO time, sampled on a window's first beat
//   counter_matched   command strobe, cmd_in valid with it
//   flush             synchronous abort that also clears sticky flags
//   rti_core_*        result FIFO write side
//   busy              capture or drain in progress
//   overflow_error    sticky, a result was dropped on a full FIFO
//   cmd_error         one-cycle pulse, command rejected while busy
//   dropped_count     saturating count of dropped results
module adc_window_capture
   import adc_capture_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH  = 256,
   parameter int SAMPLE_WIDTH     = 16,
   parameter int SAMPLES_PER_BEAT = AXIS_DATA_WIDTH / SAMPLE_WIDTH,
   parameter int ACC_WIDTH        = 48
) (
   input  logic                       s00_axis_aclk,
   input  logic                       s00_axis_aresetn,
   input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                       s00_axis_tvalid,
   output logic                       s00_axis_tready,
   input  logic [63:0]                counter,
   input  logic                       counter_matched,
   input  logic [127:0]               cmd_in,
   input  logic                       flush,
   output logic [127:0]               rti_core_fifo_din,
   output logic                       rti_core_write,
   input  logic                       rti_core_full,
   output logic                       busy,
   output logic                       overflow_error,
   output logic                       cmd_error,
   output logic [15:0]                dropped_count
);

   localparam int SUM_W   = beat_sum_w(SAMPLE_WIDTH, SAMPLES_PER_BEAT);
   localparam int RES_W   = RES_ACC_MSB - RES_ACC_LSB + 1;

   state_e      state_q, state_d;
   logic [15:0] win_len_q, win_len_d;
   logic [15:0] beat_idx_q, beat_idx_d;
   logic [31:0] win_left_q, win_left_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;
   logic        start;

   logic [15:0] cmd_win_len;
   logic [31:0] cmd_num_win;
   logic        kill, accept, first_beat, last_beat;
   logic        unused_cmd_bits;

   assign unused_cmd_bits = ^cmd_in[ABORT_BIT-1:NUM_WIN_MSB+1];

   assign cmd_win_len = (cmd_in[WIN_LEN_MSB:WIN_LEN_LSB] == '0) ? 16'd1
                                                               : cmd_in[WIN_LEN_MSB:WIN_LEN_LSB];
   assign cmd_num_win = cmd_in[NUM_WIN_MSB:NUM_WIN_LSB];

   // Abort command and flush both empty the block on the next edge; a beat
   // arriving alongside them is not counted.
   assign kill       = flush | (counter_matched & cmd_in[ABORT_BIT]);
   assign accept     = s00_axis_tvalid & (state_q == CAPTURE) & ~kill;
   assign first_beat = (beat_idx_q == '0);
   assign last_beat  = (beat_idx_q == win_len_q - 16'd1);

   always_comb begin
      state_d     = state_q;
      win_len_d   = win_len_q;
      beat_idx_d  = beat_idx_q;
      win_left_d  = win_left_q;
      drain_cnt_d = drain_cnt_q;
      start       = 1'b0;
      if (kill) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (counter_matched && cmd_num_win != '0) begin
                  state_d    = CAPTURE;
                  win_len_d  = cmd_win_len;
                  win_left_d = cmd_num_win;
                  beat_idx_d = '0;
                  start      = 1'b1;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  if (last_beat) begin
                     beat_idx_d = '0;
                     win_left_d = win_left_q - 32'd1;
                     if (win_left_q == 32'd1) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 2'(PIPE_LATENCY - 1);
                     end
                  end else begin
                     beat_idx_d = beat_idx_q + 16'd1;
                  end
               end
            end
            DRAIN: begin
               // Held until the last window's write slot has passed
               if (drain_cnt_q == '0) state_d = IDLE;
               else                   drain_cnt_d = drain_cnt_q - 2'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q     <= IDLE;
         win_len_q   <= '0;
         beat_idx_q  <= '0;
         win_left_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         win_len_q   <= win_len_d;
         beat_idx_q  <= beat_idx_d;
         win_left_q  <= win_left_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Stages 1-2: beat adder tree, tag carries first/last and timestamp
   beat_tag_t        tag_in, tag_s2;
   logic             vld_s2;
   logic [SUM_W-1:0] sum_s2;

   assign tag_in = '{first: first_beat, last: last_beat, ts: counter};

   adc_beat_adder #(
      .SAMPLE_WIDTH     (SAMPLE_WIDTH),
      .SAMPLES_PER_BEAT (SAMPLES_PER_BEAT)
   ) u_adder (
      .clk_i  (s00_axis_aclk),
      .rst_ni (s00_axis_aresetn),
      .clr_i  (kill),
      .vld_i  (accept),
      .data_i (s00_axis_tdata),
      .tag_i  (tag_in),
      .vld_o  (vld_s2),
      .sum_o  (sum_s2),
      .tag_o  (tag_s2)
   );

   // Stage 3: accumulator. A first-beat tag reloads rather than adds, so a
   // window can start on the same edge the previous one's result is built.
   logic [ACC_WIDTH-1:0] acc_q, beat_ext, acc_sum;
   logic [63:0]          ts_q, ts_win;
   logic                 res_vld_q, cmd_err_q, ovf_q, drop;
   logic [127:0]         din_q;
   logic [15:0]          drop_q;

   assign beat_ext = {{(ACC_WIDTH-SUM_W){sum_s2[SUM_W-1]}}, sum_s2};
   assign acc_sum  = tag_s2.first ? beat_ext : acc_q + beat_ext;
   assign ts_win   = tag_s2.first ? tag_s2.ts : ts_q;
   assign drop     = res_vld_q & rti_core_full;

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         acc_q     <= '0;
         ts_q      <= '0;
         res_vld_q <= 1'b0;
         din_q     <= '0;
         cmd_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
      end else begin
         if (start) begin
            acc_q <= '0;
         end else if (vld_s2) begin
            acc_q <= acc_sum;
            ts_q  <= ts_win;
         end
         res_vld_q <= vld_s2 & tag_s2.last & ~kill;
         if (vld_s2 && tag_s2.last) begin
            din_q <= {ts_win, {(RES_W-ACC_WIDTH){acc_sum[ACC_WIDTH-1]}}, acc_sum};
         end
         cmd_err_q <= counter_matched & ~cmd_in[ABORT_BIT] & ~flush & (state_q != IDLE);
         // Results are never retried: a full FIFO in the write slot loses it
         if (flush) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
         end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
      end
   end

   assign s00_axis_tready   = 1'b1;
   assign rti_core_write    = res_vld_q & ~rti_core_full;
   assign rti_core_fifo_din = din_q;
   assign busy              = (state_q != IDLE);
   assign overflow_error    = ovf_q;
   assign cmd_error         = cmd_err_q;
   assign dropped_count     = drop_q;

endmodule

// File: tb/tb_adc_window_capture.sv
// tb_adc_window_capture
//   Directed and randomized stimulus against a transaction-level model:
//   windows are tracked as beat counts and integer sums, each completed
//   window schedules an expected FIFO entry three cycles after its last beat.
module tb_adc_window_capture;

   localparam int DW  = 256;
   localparam int SW  = 16;
   localparam int SPB = DW / SW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic [63:0]   counter;
   logic          cm;
   logic [127:0]  cmd;
   logic          flush;
   logic [127:0]  din;
   logic          wr;
   logic          full;
   logic          busy;
   logic          ovf;
   logic          cerr;
   logic [15:0]   dcnt;

   adc_window_capture dut (
      .s00_axis_aclk     (clk),
      .s00_axis_aresetn  (rst_n),
      .s00_axis_tdata    (tdata),
      .s00_axis_tvalid   (tvalid),
      .s00_axis_tready   (tready),
      .counter           (counter),
      .counter_matched   (cm),
      .cmd_in            (cmd),
      .flush             (flush),
      .rti_core_fifo_din (din),
      .rti_core_write    (wr),
      .rti_core_full     (full),
      .busy              (busy),
      .overflow_error    (ovf),
      .cmd_error         (cerr),
      .dropped_count     (dcnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int           due;
      logic [127:0] val;
   } exp_t;

   exp_t    expq[$];
   bit      m_active   = 1'b0;
   int      m_drain_end = -1;
   int      m_wlen, m_wins, m_beats;
   longint  m_acc;
   logic [63:0] m_ts;
   int      m_err_cyc  = -1;
   bit      m_ovf      = 1'b0;
   int      m_drop     = 0;
   int      smp[SPB];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_cycle();
      bit           exp_wr;
      logic [127:0] exp_din;
      exp_wr  = 1'b0;
      exp_din = '0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         exp_wr  = !full;
         exp_din = expq[0].val;
      end
      chk("write", wr, exp_wr);
      if (exp_wr) chk("din", din, exp_din);
      chk("busy", busy, m_active || cyc <= m_drain_end);
      chk("cmd_error", cerr, m_err_cyc == cyc);
      chk("overflow", ovf, m_ovf);
      chk("dropped", dcnt, m_drop);
      chk("tready", tready, 1'b1);
   endtask

   // Consumes this cycle's inputs and advances the transaction model
   task automatic model_step();
      bit          busy_now, was_active, kill;
      longint      s;
      logic [47:0] a48;
      busy_now   = m_active || cyc <= m_drain_end;
      was_active = m_active;
      kill       = flush || (cm && cmd[127]);
      if (expq.size() > 0 && expq[0].due == cyc) begin
         if (full) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
         void'(expq.pop_front());
      end
      if (kill) begin
         m_active    = 1'b0;
         m_drain_end = -1;
         expq.delete();
         if (flush) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end
      end else begin
         if (cm) begin
            if (busy_now) begin
               m_err_cyc = cyc + 1;
            end else if (cmd[47:16] != 0) begin
               m_active = 1'b1;
               m_wlen   = (cmd[15:0] == 0) ? 1 : int'(cmd[15:0]);
               m_wins   = int'(cmd[47:16]);
               m_beats  = 0;
               m_acc    = 0;
            end
         end
         if (was_active && tvalid) begin
            s = 0;
            for (int i = 0; i < SPB; i++) s += smp[i];
            if (m_beats == 0) m_ts = counter;
            m_acc += s;
            m_beats++;
            if (m_beats == m_wlen) begin
               a48 = m_acc[47:0];
               expq.push_back('{due: cyc + 3, val: {m_ts, {16{a48[47]}}, a48}});
               m_beats = 0;
               m_acc   = 0;
               m_wins--;
               if (m_wins == 0) begin
                  m_active    = 1'b0;
                  m_drain_end = cyc + 3;
               end
            end
         end
      end
   endtask

   task automatic tick();
      #2;
      check_cycle();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      counter = counter + 64'd1;
      cm      = 1'b0;
      cmd     = '0;
      tvalid  = 1'b0;
      flush   = 1'b0;
      full    = 1'b0;
      for (int i = 0; i < DW / 32; i++) tdata[i*32 +: 32] = $urandom;
   endtask

   task automatic pack();
      for (int i = 0; i < SPB; i++) tdata[i*SW +: SW] = 16'(smp[i]);
      tvalid = 1'b1;
   endtask

   task automatic set_cmd(input int wl, input int nw, input bit ab);
      cm         = 1'b1;
      cmd        = '0;
      cmd[15:0]  = 16'(wl);
      cmd[47:16] = 32'(nw);
      cmd[127]   = ab;
   endtask

   task automatic send_cmd(input int wl, input int nw, input bit ab);
      set_cmd(wl, nw, ab);
      tick();
   endtask

   task automatic set_rand_beat();
      for (int i = 0; i < SPB; i++) smp[i] = int'($urandom_range(65535)) - 32768;
      pack();
   endtask

   task automatic beat_fill(input int v);
      for (int i = 0; i < SPB; i++) smp[i] = v;
      pack();
      tick();
   endtask

   task automatic beat_rand();
      set_rand_beat();
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      rst_n = 1'b1; tvalid = 1'b0; tdata = '0; cm = 1'b0; cmd = '0;
      flush = 1'b0; full = 1'b0; counter = '0;
      #1 rst_n = 1'b0;
      #3;
      chk("rst_write", wr, 1'b0);
      chk("rst_din", din, 128'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_cmd_error", cerr, 1'b0);
      chk("rst_dropped", dcnt, 16'd0);
      chk("rst_tready", tready, 1'b1);
      #8 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;

      // Single window, timestamp of first beat
      counter = 64'd1000;
      send_cmd(2, 1, 1'b0);
      idle(4);
      beat_fill(1);
      beat_fill(1);
      idle(5);

      // Extremes and mixed signs, back-to-back one-beat windows
      send_cmd(1, 3, 1'b0);
      beat_fill(-32768);
      beat_fill(32767);
      for (int i = 0; i < SPB; i++) smp[i] = (i % 2 == 0) ? 100 : -100;
      pack();
      tick();
      idle(5);

      // FIFO full during the second of three write slots
      send_cmd(1, 3, 1'b0);
      beat_rand();
      beat_rand();
      beat_rand();
      tick();
      full = 1'b1;
      tick();
      tick();
      idle(3);

      // Abort mid-window, then a normal capture
      send_cmd(10, 1, 1'b0);
      repeat (4) beat_rand();
      set_rand_beat();
      set_cmd(0, 0, 1'b1);
      tick();
      idle(3);
      send_cmd(3, 2, 1'b0);
      repeat (6) beat_rand();
      idle(5);

      // Rejected commands during capture and during drain
      send_cmd(4, 2, 1'b0);
      beat_rand();
      beat_rand();
      set_rand_beat();
      set_cmd(2, 1, 1'b0);
      tick();
      repeat (5) beat_rand();
      send_cmd(1, 1, 1'b0);
      idle(5);

      // Zero fields and tvalid gaps
      send_cmd(0, 2, 1'b0);
      beat_rand();
      beat_rand();
      idle(4);
      send_cmd(5, 0, 1'b0);
      beat_rand();
      idle(3);
      send_cmd(3, 1, 1'b0);
      beat_rand();
      idle(5);
      beat_rand();
      idle(5);
      beat_rand();
      idle(5);

      // Flush mid-capture clears sticky flags
      send_cmd(2, 3, 1'b0);
      repeat (3) beat_rand();
      flush = 1'b1;
      tick();
      idle(3);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(3) != 0) set_rand_beat();
         if ($urandom_range(15) == 0)
            set_cmd(int'($urandom_range(3)), int'($urandom_range(3)), $urandom_range(7) == 0);
         full  = ($urandom_range(3) == 0);
         flush = ($urandom_range(127) == 0);
         tick();
      end
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
